arch_state_dumper: RTL and testbench

- Sits directly downstream of the single-cycle CPU.
- When the CPU asserts halt, the block walks the register file and then data memory, using its own read ports.
- It emits every architectural word on a valid/ready stream, so the final state can be drained word by word to a host/UART bridge.
- This replaces the end-of-simulation file dump with synthesizable hardware.

---
 rtl/arch_state_dumper_if.sv | 30 +++
 rtl/arch_state_dumper.sv | 162 ++++++++++++++++
 tb/tb_arch_state_dumper.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arch_state_dumper_if.sv
// Output stream of the architectural state dumper.
//
// Handshake: a word transfers on a rising clk edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, the producer holds out_data,
// out_is_mem and out_index stable. out_ready is ignored while out_valid is low.
interface arch_state_dumper_if #(
    parameter int IDX_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_is_mem;
    logic [IDX_W-1:0] out_index;

    modport master (
        output out_valid,
        output out_data,
        output out_is_mem,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_is_mem,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/arch_state_dumper.sv
// Architectural state dumper: after the CPU halts, walks the register file and
// then data memory through its own read ports and streams every word out.
// Optional checksum word after the memory words: define DUMP_CHECKSUM_EN.
module arch_state_dumper #(
    parameter int NUM_REGS  = 32,
    parameter int MEM_WORDS = 256,
    parameter int IDX_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_in,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    arch_state_dumper_if.master out_s,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state_dbg
);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REGS = 3'd1,
        S_MEM  = 3'd2,
        S_DONE = 3'd3,
        S_CSUM = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REGS = 3'd1,
        S_MEM  = 3'd2,
        S_DONE = 3'd3
    } state_t;
`endif

    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(MEM_WORDS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      mem_word;
    logic             xfer;

`ifdef DUMP_CHECKSUM_EN
    logic [31:0]      csum_q;
`endif

    assign mem_word  = 32'(idx_q);
    assign xfer      = out_s.out_valid && out_s.out_ready;
    assign state_dbg = state_q;

    // State and index registers; reset aborts any dump in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Running sum of every data word accepted downstream, restarted per dump.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (state_q == S_IDLE && halt_in) begin
            csum_q <= '0;
        end else if (xfer && (state_q == S_REGS || state_q == S_MEM)) begin
            csum_q <= csum_q + out_s.out_data;
        end
    end
`endif

    // Next state, index advance and stream outputs; data passes straight through
    // from the read ports so a stalled word stays stable with stable storage.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        rf_raddr         = '0;
        mem_raddr        = '0;
        out_s.out_valid  = 1'b0;
        out_s.out_data   = '0;
        out_s.out_is_mem = 1'b0;
        out_s.out_index  = '0;
        busy             = 1'b0;
        done             = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (halt_in) begin
                    state_d = S_REGS;
                    idx_d   = '0;
                end
            end

            S_REGS: begin
                rf_raddr        = idx_q[4:0];
                out_s.out_valid = 1'b1;
                out_s.out_data  = rf_rdata;
                out_s.out_index = idx_q;
                busy            = 1'b1;
                if (out_s.out_ready) begin
                    if (idx_q == LAST_REG) begin
                        state_d = S_MEM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_MEM: begin
                mem_raddr        = mem_word << 2;
                out_s.out_valid  = 1'b1;
                out_s.out_data   = mem_rdata;
                out_s.out_is_mem = 1'b1;
                out_s.out_index  = idx_q;
                busy             = 1'b1;
                if (out_s.out_ready) begin
                    if (idx_q == LAST_MEM) begin
`ifdef DUMP_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                out_s.out_valid  = 1'b1;
                out_s.out_data   = csum_q;
                out_s.out_is_mem = 1'b1;
                out_s.out_index  = '1;
                busy             = 1'b1;
                if (out_s.out_ready) begin
                    state_d = S_DONE;
                end
            end
`endif

            S_DONE: begin
                done = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_arch_state_dumper.sv
// Bench for arch_state_dumper: a full-size instance (32 regs, 256 mem words)
// and a boundary instance (32 regs, 1 mem word) share behavioural storage.
module tb_arch_state_dumper;

    localparam int EW = 49;  // {is_mem, index[15:0], data[31:0]}
`ifdef DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int N_A = 32 + 256 + CS;
    localparam int N_B = 32 + 1 + CS;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halt = 1'b0;
    logic ready = 1'b0;
    logic halt_b = 1'b0;
    logic ready_b = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural storage
    logic [31:0] rf_m [32];
    logic [31:0] dm   [256];

    // DUT A
    logic [4:0]  rf_raddr_a;
    logic [31:0] rf_rdata_a, mem_raddr_a, mem_rdata_a;
    logic        busy_a, done_a;
    logic [2:0]  state_a;
    arch_state_dumper_if #(.IDX_W(16)) sa ();
    assign sa.out_ready = ready;
    assign rf_rdata_a   = rf_m[rf_raddr_a];
    assign mem_rdata_a  = dm[mem_raddr_a[9:2]];

    arch_state_dumper #(.NUM_REGS(32), .MEM_WORDS(256), .IDX_W(16)) dut_a (
        .clk(clk), .rst(rst), .halt_in(halt),
        .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a),
        .mem_raddr(mem_raddr_a), .mem_rdata(mem_rdata_a),
        .out_s(sa), .busy(busy_a), .done(done_a), .state_dbg(state_a)
    );

    // DUT B (single memory word)
    logic [4:0]  rf_raddr_b;
    logic [31:0] rf_rdata_b, mem_raddr_b, mem_rdata_b;
    logic        busy_b, done_b;
    logic [2:0]  state_b;
    arch_state_dumper_if #(.IDX_W(16)) sb ();
    assign sb.out_ready = ready_b;
    assign rf_rdata_b   = rf_m[rf_raddr_b];
    assign mem_rdata_b  = dm[mem_raddr_b[9:2]];

    arch_state_dumper #(.NUM_REGS(32), .MEM_WORDS(1), .IDX_W(16)) dut_b (
        .clk(clk), .rst(rst), .halt_in(halt_b),
        .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b),
        .mem_raddr(mem_raddr_b), .mem_rdata(mem_rdata_b),
        .out_s(sb), .busy(busy_b), .done(done_b), .state_dbg(state_b)
    );

    // scoreboard
    logic [EW-1:0] exp_a[$];
    logic [EW-1:0] exp_b[$];
    int total = 0;
    int bad = 0;
    int run_a = 0;
    int run_b = 0;
    int last_xfer_a = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_dump(input int nmem, input bit to_b);
        logic [31:0]   sum;
        logic [EW-1:0] w;
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            w = {1'b0, 16'(i), rf_m[i]};
            sum += rf_m[i];
            if (to_b) exp_b.push_back(w); else exp_a.push_back(w);
        end
        for (int j = 0; j < nmem; j++) begin
            w = {1'b1, 16'(j), dm[j]};
            sum += dm[j];
            if (to_b) exp_b.push_back(w); else exp_a.push_back(w);
        end
`ifdef DUMP_CHECKSUM_EN
        w = {1'b1, 16'hFFFF, sum};
        if (to_b) exp_b.push_back(w); else exp_a.push_back(w);
`endif
    endtask

    // monitor A: pops on every handshake, checks stall stability and addresses
    logic          stall_a = 1'b0;
    logic [EW-1:0] last_a;
    always @(negedge clk) begin
        logic [EW-1:0] cur, e;
        cur = {sa.out_is_mem, sa.out_index, sa.out_data};
        if (rst) begin
            stall_a = 1'b0;
        end else begin
            if (sa.out_valid && stall_a) chk("a_stall_stable", 64'(cur), 64'(last_a));
            if (sa.out_valid && !sa.out_is_mem) chk("a_rf_raddr", 64'(rf_raddr_a), 64'(sa.out_index[4:0]));
            if (sa.out_valid && sa.out_is_mem && sa.out_index != 16'hFFFF)
                chk("a_mem_raddr", 64'(mem_raddr_a), 64'({sa.out_index, 2'b00}));
            if (sa.out_valid && sa.out_ready) begin
                if (exp_a.size() == 0) begin
                    chk("a_unexpected_word", 64'(cur), 64'(0));
                end else begin
                    e = exp_a.pop_front();
                    chk("a_word", 64'(cur), 64'(e));
                end
                run_a++;
                last_xfer_a = cyc + 1;
            end
            stall_a = sa.out_valid && !sa.out_ready;
            last_a  = cur;
        end
    end

    // monitor B
    always @(negedge clk) begin
        logic [EW-1:0] cur, e;
        cur = {sb.out_is_mem, sb.out_index, sb.out_data};
        if (!rst) begin
            if (sb.out_valid && !sb.out_is_mem) chk("b_rf_raddr", 64'(rf_raddr_b), 64'(sb.out_index[4:0]));
            if (sb.out_valid && sb.out_is_mem && sb.out_index != 16'hFFFF)
                chk("b_mem_raddr", 64'(mem_raddr_b), 64'(0));
            if (sb.out_valid && ready_b) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected_word", 64'(cur), 64'(0));
                end else begin
                    e = exp_b.pop_front();
                    chk("b_word", 64'(cur), 64'(e));
                end
                run_b++;
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        rst = 1'b1;
        halt = 1'b0;
        halt_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(sa.out_valid), 64'(0));
        chk("rst_busy", 64'(busy_a), 64'(0));
        chk("rst_done", 64'(done_a), 64'(0));
        chk("rst_index", 64'(sa.out_index), 64'(0));
        chk("rst_is_mem", 64'(sa.out_is_mem), 64'(0));
        chk("rst_rf_raddr", 64'(rf_raddr_a), 64'(0));
        chk("rst_mem_raddr", 64'(mem_raddr_a), 64'(0));
        chk("rst_b_busy_done", 64'({busy_b, done_b}), 64'(0));
        exp_a.delete();
        exp_b.delete();
        run_a = 0;
        run_b = 0;
        rst = 1'b0;
    endtask

    task automatic wait_done(input bit is_b, input int max, input bit rnd, input bit drop_halt);
        int n;
        n = 0;
        while (!(is_b ? done_b : done_a) && n < max) begin
            @(posedge clk);
            #1;
            if (rnd) ready = 1'($urandom_range(0, 1));
            if (drop_halt && run_a >= 5) halt = 1'b0;
            n++;
        end
        chk(is_b ? "b_done_reached" : "a_done_reached", 64'(is_b ? done_b : done_a), 64'(1));
    endtask

    // main sequence
    initial begin
        int c0, n;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'(i * 32'h11);
        for (int j = 0; j < 256; j++) dm[j] = 32'hA500_0000 + 32'(j);
        ready = 1'b1;

        // reset and idle with halt low
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        chk("idle_no_transfers", 64'(run_a), 64'(0));
        chk("idle_valid", 64'(sa.out_valid), 64'(0));

        // full dump with ready held high
        push_dump(256, 1'b0);
        @(posedge clk);
        #1 halt = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        chk("first_valid", 64'(sa.out_valid), 64'(1));
        chk("first_index", 64'(sa.out_index), 64'(0));
        chk("first_data", 64'(sa.out_data), 64'(0));
        chk("first_busy", 64'(busy_a), 64'(1));
        wait_done(1'b0, 2000, 1'b0, 1'b0);
        chk("full_cycles", 64'(cyc - c0), 64'(N_A));
        chk("done_after_last", 64'(cyc), 64'(last_xfer_a));
        chk("full_count", 64'(run_a), 64'(N_A));
        chk("full_queue_empty", 64'(exp_a.size()), 64'(0));
        chk("done_busy", 64'(busy_a), 64'(0));
        chk("done_valid", 64'(sa.out_valid), 64'(0));
        halt = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("done_sticky_halt_low", 64'(done_a), 64'(1));
        halt = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("done_sticky_halt_high", 64'({done_a, sa.out_valid}), 64'(2'b10));

        // backpressure with halt dropped after 5 transfers
        do_reset();
        push_dump(256, 1'b0);
        halt = 1'b1;
        wait_done(1'b0, 5000, 1'b1, 1'b1);
        ready = 1'b1;
        chk("bp_count", 64'(run_a), 64'(N_A));
        chk("bp_queue_empty", 64'(exp_a.size()), 64'(0));

        // reset at transfer 100, halt held so restart follows reset release
        do_reset();
        push_dump(256, 1'b0);
        halt = 1'b1;
        n = 0;
        while (run_a < 100 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_reached_100", 64'(run_a), 64'(100));
        rst = 1'b1;
        ready = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 64'(sa.out_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy_a), 64'(0));
        chk("mid_rst_index", 64'(sa.out_index), 64'(0));
        exp_a.delete();
        run_a = 0;
        push_dump(256, 1'b0);
        rst = 1'b0;
        ready = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_valid", 64'(sa.out_valid), 64'(1));
        chk("restart_index", 64'({sa.out_is_mem, sa.out_index}), 64'(0));
        wait_done(1'b0, 2000, 1'b0, 1'b0);
        chk("restart_count", 64'(run_a), 64'(N_A));
        chk("restart_queue_empty", 64'(exp_a.size()), 64'(0));

        // boundary: single memory word
        do_reset();
        push_dump(1, 1'b1);
        ready_b = 1'b1;
        halt_b = 1'b1;
        wait_done(1'b1, 500, 1'b0, 1'b0);
        chk("b_count", 64'(run_b), 64'(N_B));
        chk("b_queue_empty", 64'(exp_b.size()), 64'(0));
        chk("b_busy_after", 64'({busy_b, sb.out_valid}), 64'(0));

`ifdef DUMP_CHECKSUM_EN
        // checksum wrap-around: 288 * 0xFFFFFFFF mod 2^32
        do_reset();
        for (int i = 0; i < 32; i++) rf_m[i] = 32'hFFFF_FFFF;
        for (int j = 0; j < 256; j++) dm[j] = 32'hFFFF_FFFF;
        push_dump(256, 1'b0);
        exp_a.pop_back();
        exp_a.push_back({1'b1, 16'hFFFF, 32'hFFFF_FEE0});
        halt = 1'b1;
        wait_done(1'b0, 2000, 1'b0, 1'b0);
        chk("csum_count", 64'(run_a), 64'(N_A));
        chk("csum_queue_empty", 64'(exp_a.size()), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
